alu_top: RTL and testbench

ALU_TOP -- requirements
Module: alu_top

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/bin2bcd.sv | 23 ++
 rtl/alu_top.sv | 80 ++++++++
 tb/tb_alu_top.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, saturation limit, opcode encodings and the ALU datapath function.
package alu_pkg;

    localparam int OP_W  = 6;
    localparam int BIN_W = 10;
    localparam int RES_W = 12;
    localparam int BCD_W = 12;
    localparam logic [RES_W-1:0] SAT_LIM = 12'd999;

    localparam logic [3:0] OP_ADD     = 4'b1000;
    localparam logic [3:0] OP_SUB     = 4'b1001;
    localparam logic [3:0] OP_MOD     = 4'b1010;
    localparam logic [3:0] OP_MUL     = 4'b1011;
    localparam logic [3:0] OP_DIV     = 4'b1100;
    localparam logic [3:0] OP_NOT     = 4'b1101;
    localparam logic [3:0] OP_AND     = 4'b1110;
    localparam logic [3:0] OP_OR      = 4'b1111;
    localparam logic [3:0] OP_XOR     = 4'b0000;
    localparam logic [3:0] OP_SR      = 4'b0001;
    localparam logic [3:0] OP_SL      = 4'b0010;
    localparam logic [3:0] OP_SUB_ALT = 4'b0011;

    // Full-width result is clamped so the 3-digit BCD stage never overflows.
    function automatic logic [BIN_W-1:0] alu_calc(input logic [3:0] op,
                                                  input logic [OP_W-1:0] a,
                                                  input logic [OP_W-1:0] b);
        logic [RES_W-1:0] aw, bw, r;
        aw = {{(RES_W-OP_W){1'b0}}, a};
        bw = {{(RES_W-OP_W){1'b0}}, b};
        case (op)
            OP_ADD:             r = aw + bw;
            OP_SUB, OP_SUB_ALT: r = (b > a) ? '0 : aw - bw;
            OP_MOD:             r = (b == '0) ? aw : aw % bw;
            OP_MUL:             r = aw * bw;
            OP_DIV:             r = (b == '0) ? 12'd63 : aw / bw;
            OP_NOT:             r = {{(RES_W-OP_W){1'b0}}, ~a};
            OP_AND:             r = aw & bw;
            OP_OR:              r = aw | bw;
            OP_XOR:             r = aw ^ bw;
            OP_SL:              r = aw << 1;
            OP_SR:              r = aw >> 1;
            default:            r = '0;
        endcase
        if (r > SAT_LIM)
            r = SAT_LIM;
        return r[BIN_W-1:0];
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// Combinational double-dabble: 10-bit binary to three BCD digits.
module bin2bcd
    import alu_pkg::*;
(
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd
);

    logic [BCD_W+BIN_W-1:0] sr;

    always_comb begin
        sr = {{BCD_W{1'b0}}, bin};
        for (int i = 0; i < BIN_W; i++) begin
            for (int d = 0; d < 3; d++) begin
                if (sr[BIN_W+4*d +: 4] >= 4'd5)
                    sr[BIN_W+4*d +: 4] = sr[BIN_W+4*d +: 4] + 4'd3;
            end
            sr = sr << 1;
        end
        bcd = sr[BCD_W+BIN_W-1:BIN_W];
    end

endmodule

// File: rtl/alu_top.sv
// Serially-loaded 4-bit opcode ALU with registered BCD result.
// Define ALU_INPUT_SYNC_EN to add 2-flop synchronizers on the load/clear inputs.
module alu_top
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset_all,
    input  logic             reset_instr,
    input  logic             instr_load_en,
    input  logic             instruction_in,
    input  logic [OP_W-1:0]  A,
    input  logic [OP_W-1:0]  B,
    output logic [BCD_W-1:0] bcd_result
);

    logic             load_i, instr_i, rst_i;
    logic             load_q;
    logic [3:0]       opcode;
    logic [2:0]       bit_cnt;
    logic             op_done;
    logic             load_edge;
    logic [BIN_W-1:0] bin_res;
    logic [BCD_W-1:0] bcd_next;

`ifdef ALU_INPUT_SYNC_EN
    logic [1:0] load_sync, instr_sync, rsti_sync;

    // Clear input idles high so reset release does not look like a clear.
    always_ff @(posedge clk or negedge reset_all) begin
        if (!reset_all) begin
            load_sync  <= 2'b00;
            instr_sync <= 2'b00;
            rsti_sync  <= 2'b11;
        end else begin
            load_sync  <= {load_sync[0], instr_load_en};
            instr_sync <= {instr_sync[0], instruction_in};
            rsti_sync  <= {rsti_sync[0], reset_instr};
        end
    end

    assign load_i  = load_sync[1];
    assign instr_i = instr_sync[1];
    assign rst_i   = rsti_sync[1];
`else
    assign load_i  = instr_load_en;
    assign instr_i = instruction_in;
    assign rst_i   = reset_instr;
`endif

    assign load_edge = load_i & ~load_q;
    assign op_done   = (bit_cnt == 3'd4);
    assign bin_res   = alu_calc(opcode, A, B);

    bin2bcd u_bin2bcd (
        .bin (bin_res),
        .bcd (bcd_next)
    );

    always_ff @(posedge clk or negedge reset_all) begin
        if (!reset_all) begin
            load_q     <= 1'b0;
            opcode     <= '0;
            bit_cnt    <= '0;
            bcd_result <= '0;
        end else if (!rst_i) begin
            load_q     <= 1'b0;
            opcode     <= '0;
            bit_cnt    <= '0;
            bcd_result <= '0;
        end else begin
            load_q <= load_i;
            if (load_edge && !op_done) begin
                opcode  <= {instr_i, opcode[3:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            bcd_result <= op_done ? bcd_next : '0;
        end
    end

endmodule

// File: tb/tb_alu_top.sv
// Directed-vector bench for alu_top with a queue-based scoreboard and monitor.
module tb_alu_top;

    logic        clk = 1'b0;
    logic        reset_all = 1'b0;
    logic        reset_instr = 1'b1;
    logic        instr_load_en = 1'b0;
    logic        instruction_in = 1'b0;
    logic [5:0]  A = 6'd21;
    logic [5:0]  B = 6'd17;
    logic [11:0] bcd_result;

    typedef struct {
        string       name;
        logic [11:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    alu_top dut (
        .clk            (clk),
        .reset_all      (reset_all),
        .reset_instr    (reset_instr),
        .instr_load_en  (instr_load_en),
        .instruction_in (instruction_in),
        .A              (A),
        .B              (B),
        .bcd_result     (bcd_result)
    );

    always #5 clk = ~clk;

    // Monitor: compares the output on the falling edge whenever an expectation is pending.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bcd_result !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, bcd_result, e.val);
            end
        end
    end

    task automatic check(input string n, input logic [11:0] v);
        exp_q.push_back('{n, v});
        @(negedge clk);
        #1;
    endtask

    task automatic strobe(input logic b, input int len);
        instruction_in = b;
        instr_load_en  = 1'b1;
        repeat (len) @(posedge clk);
        #1 instr_load_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic load_op(input logic [3:0] op);
        for (int i = 0; i < 4; i++)
            strobe(op[i], 3);
    endtask

    task automatic clr_instr();
        @(posedge clk);
        #1 reset_instr = 1'b0;
        @(posedge clk);
        #1 reset_instr = 1'b1;
    endtask

    logic [3:0]  sw_op  [11] = '{4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110,
                                 4'b1111, 4'b0000, 4'b0010, 4'b0001, 4'b0011};
    logic [11:0] sw_exp [11] = '{12'h004, 12'h004, 12'h357, 12'h001, 12'h042, 12'h017,
                                 12'h021, 12'h004, 12'h042, 12'h010, 12'h004};

    initial begin
        logic [3:0] add_op;
        add_op = 4'b1000;
        check("reset_state", 12'h000);
        #2 reset_all = 1'b1;
        @(posedge clk);
        #1;

        // ADD with long strobes; output stays 0 until the 4th bit lands.
        for (int i = 0; i < 3; i++)
            strobe(add_op[i], 6);
        check("add_partial", 12'h000);
        strobe(add_op[3], 6);
        check("add_done", 12'h038);

        // Operand change propagates one cycle later.
        A = 6'd10;
        @(posedge clk);
        #1;
        check("add_operand_change", 12'h027);
        A = 6'd21;
        @(posedge clk);
        #1;

        for (int k = 0; k < 11; k++) begin
            clr_instr();
            load_op(sw_op[k]);
            check($sformatf("sweep_%b", sw_op[k]), sw_exp[k]);
        end

        clr_instr();
        A = 6'd63; B = 6'd63;
        load_op(4'b1011);
        check("mul_saturate", 12'h999);

        clr_instr();
        A = 6'd3; B = 6'd9;
        load_op(4'b1001);
        check("sub_underflow", 12'h000);

        clr_instr();
        A = 6'd21; B = 6'd0;
        load_op(4'b1100);
        check("div_by_zero", 12'h063);

        clr_instr();
        load_op(4'b1010);
        check("mod_by_zero", 12'h021);

        // Async reset while a result is showing clears it before any clock edge.
        B = 6'd17;
        @(posedge clk);
        #1 reset_all = 1'b0;
        #1;
        check("reset_all_immediate", 12'h000);
        reset_all = 1'b1;
        @(posedge clk);
        #1;

        // Async reset mid-load; the next load must start again at bit 0.
        clr_instr();
        strobe(1'b1, 3);
        strobe(1'b1, 3);
        reset_all = 1'b0;
        #1;
        check("reset_all_midload", 12'h000);
        reset_all = 1'b1;
        @(posedge clk);
        #1;
        load_op(4'b1000);
        check("add_after_reset_all", 12'h038);

        // Fifth strobe ignored; clear then reload.
        strobe(1'b1, 3);
        check("fifth_strobe_ignored", 12'h038);
        @(posedge clk);
        #1 reset_instr = 1'b0;
        @(posedge clk);
        #1 reset_instr = 1'b1;
        check("reset_instr_clear", 12'h000);
        load_op(4'b1001);
        check("reload_after_clear", 12'h004);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
